// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST wrapper (LFSR pattern source + MISR compactor).
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  localparam int          IN_W_DEF      = 16;
  localparam int          OUT_W_DEF     = 10;
  localparam logic [15:0] LFSR16_TAPS   = 16'hB400;
  localparam logic [9:0]  MISR_POLY_DEF = 10'h009;

  // Fibonacci step: shift left, feedback is the parity of bits 15,13,12,10.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR16_TAPS)};
  endfunction

endpackage

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register: load has priority over enable, reset returns to the seed.
module gate_bist_misr
  import gate_bist_pkg::*;
#(
  parameter int           W    = OUT_W_DEF,
  parameter logic [W-1:0] POLY = W'(MISR_POLY_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = ({sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0)) ^ data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= seed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST wrapper: LFSR drives the gate model, MISR compacts its response, signature compared at end of run.
// Optional build macro GATE_BIST_PAUSE_EN adds a pause input that freezes a run in progress.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int               IN_W      = IN_W_DEF,
  parameter int               OUT_W     = OUT_W_DEF,
  parameter int               PAT_CNT   = 256,
  parameter logic [IN_W-1:0]  LFSR_SEED = IN_W'(16'hACE1),
  parameter logic [OUT_W-1:0] MISR_SEED = '0,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(MISR_POLY_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] expected_sig,
  input  logic [OUT_W-1:0] resp_in,
`ifdef GATE_BIST_PAUSE_EN
  input  logic             pause,
`endif
  output logic [IN_W-1:0]  pat_out,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature,
  output logic             pass,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (PAT_CNT >= 1) ? $clog2(PAT_CNT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAT_CNT - 1);

  if (PAT_CNT < 1) begin : g_bad_pat_cnt
    $error("gate_bist_ctrl: PAT_CNT must be >= 1");
  end
  if (LFSR_SEED == '0) begin : g_bad_lfsr_seed
    $error("gate_bist_ctrl: LFSR_SEED must be nonzero");
  end
  if (IN_W != 16) begin : g_bad_in_w
    $error("gate_bist_ctrl: LFSR taps are defined for a 16-bit pattern only");
  end

  bist_state_e      state_q, state_d;
  logic [IN_W-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             hold;
  logic             advance;
  logic             last_cap;
  logic             misr_load;
  logic             misr_en;
  logic [OUT_W-1:0] sig;

`ifdef GATE_BIST_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // start is a level sampled only in IDLE; there is no back-pressure, a run cannot be refused or queued.
  assign advance  = (state_q == RUN) && !hold;
  assign last_cap = advance && (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_cap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pat_d     = LFSR_SEED;
          cnt_d     = '0;
          pass_d    = 1'b0;
          misr_load = 1'b1;
        end
      end
      RUN: begin
        if (advance) begin
          misr_en = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          // The final capture leaves the pattern on the bus so the gate model stays stable.
          if (!last_cap) pat_d = lfsr16_next(pat_q);
        end
      end
      DONE:    pass_d = (sig == expected_sig);
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  gate_bist_misr #(
    .W    (OUT_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .load    (misr_load),
    .en      (misr_en),
    .seed    (MISR_SEED),
    .data_in (resp_in),
    .sig     (sig)
  );

  assign pat_out   = pat_q;
  assign signature = sig;
  assign pass      = pass_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: four instances cover the small-run, MISR and full-length cases.
`timescale 1ns/1ps
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u_a: PAT_CNT=4, LFSR_SEED=1
  logic        start_a;
  logic [9:0]  exp_a, resp_a, sig_a;
  logic [15:0] pat_a;
  logic        busy_a, done_a, pass_a;
  logic [1:0]  st_a;
`ifdef GATE_BIST_PAUSE_EN
  logic        pause_a;
`endif
  // u_b: PAT_CNT=2, MISR_SEED=0
  logic        start_b;
  logic [9:0]  exp_b, resp_b, sig_b;
  logic [15:0] pat_b;
  logic        busy_b, done_b, pass_b;
  logic [1:0]  st_b;
  // u_c: PAT_CNT=1, MISR_SEED=0x200
  logic        start_c;
  logic [9:0]  exp_c, resp_c, sig_c;
  logic [15:0] pat_c;
  logic        busy_c, done_c, pass_c;
  logic [1:0]  st_c;
  // u_d: all defaults
  logic        start_d;
  logic [9:0]  exp_d, resp_d, sig_d;
  logic [15:0] pat_d;
  logic        busy_d, done_d, pass_d;
  logic [1:0]  st_d;

  gate_bist_ctrl #(.PAT_CNT(4), .LFSR_SEED(16'h0001), .MISR_SEED(10'h000)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .expected_sig(exp_a), .resp_in(resp_a),
`ifdef GATE_BIST_PAUSE_EN
    .pause(pause_a),
`endif
    .pat_out(pat_a), .busy(busy_a), .done(done_a), .signature(sig_a), .pass(pass_a),
    .dbg_state(st_a));

  gate_bist_ctrl #(.PAT_CNT(2), .MISR_SEED(10'h000)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .expected_sig(exp_b), .resp_in(resp_b),
`ifdef GATE_BIST_PAUSE_EN
    .pause(1'b0),
`endif
    .pat_out(pat_b), .busy(busy_b), .done(done_b), .signature(sig_b), .pass(pass_b),
    .dbg_state(st_b));

  gate_bist_ctrl #(.PAT_CNT(1), .MISR_SEED(10'h200)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .expected_sig(exp_c), .resp_in(resp_c),
`ifdef GATE_BIST_PAUSE_EN
    .pause(1'b0),
`endif
    .pat_out(pat_c), .busy(busy_c), .done(done_c), .signature(sig_c), .pass(pass_c),
    .dbg_state(st_c));

  gate_bist_ctrl u_d (
    .clk(clk), .rst(rst), .start(start_d), .expected_sig(exp_d), .resp_in(resp_d),
`ifdef GATE_BIST_PAUSE_EN
    .pause(1'b0),
`endif
    .pat_out(pat_d), .busy(busy_d), .done(done_d), .signature(sig_d), .pass(pass_d),
    .dbg_state(st_d));

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] p);
    logic fb;
    fb = ($countones(p & 16'hB400) % 2) == 1;
    return {p[14:0], fb};
  endfunction

  // Multiply by x modulo x^10+x^3+1, then add the response word.
  function automatic logic [9:0] misr_step(input logic [9:0] s, input logic [9:0] d);
    logic [10:0] x;
    x = {s, 1'b0};
    if (x[10]) x = x ^ 11'h409;
    return x[9:0] ^ d;
  endfunction

  logic [15:0] exp_q[$];
  logic [15:0] obs_pat[$];
  logic [15:0] exp_pat_q[$];
  logic [9:0]  obs_sig[$];
  logic [9:0]  exp_sig_q[$];
  bit          obs_paused[$];
  logic [9:0]  sig_at_done, model_sig, trail_sig;
  logic [15:0] trail_pat;
  logic        pass_after;
  int          done_edge, done_pulses, busy_cycles, trail_busy, trail_done;

  // ---------------- driver for u_a ----------------
  // resp_mode: 0 all-zero, 1 random, 2 deterministic function of capture index.
  task automatic drive_run_a(input int pause_at, input int pause_len, input int resp_mode,
                             input bit extra_starts, input bit want_match);
    int          edges;
    int          caps;
    int          pleft;
    bit          paused;
    logic [9:0]  resp;
    logic [9:0]  run_sig;
    logic [15:0] p;
    exp_q.delete(); obs_pat.delete(); exp_pat_q.delete();
    obs_sig.delete(); exp_sig_q.delete(); obs_paused.delete();
    p = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(p);
      p = lfsr_step(p);
    end
    done_edge = -1; done_pulses = 0; busy_cycles = 0;
    edges = 0; caps = 0; pleft = pause_len; run_sig = 10'h000;
    @(negedge clk);
    start_a = 1'b1;
    while (edges < 60 && done_edge < 0) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start_a = 1'b0;
      resp_a  = 10'(($urandom));
`ifdef GATE_BIST_PAUSE_EN
      pause_a = 1'b0;
`endif
      if (done_a) begin
        done_pulses++;
        done_edge   = edges;
        sig_at_done = sig_a;
        model_sig   = run_sig;
        exp_a       = want_match ? run_sig : (run_sig ^ 10'h155);
        if (extra_starts) start_a = 1'b1;
      end else if (busy_a) begin
        busy_cycles++;
        paused = (caps == pause_at) && (pleft > 0);
        obs_pat.push_back(pat_a);
        obs_sig.push_back(sig_a);
        obs_paused.push_back(paused);
        exp_pat_q.push_back(caps < 4 ? exp_q[caps] : 16'hxxxx);
        exp_sig_q.push_back(run_sig);
        case (resp_mode)
          0:       resp = 10'h000;
          1:       resp = 10'($urandom);
          default: resp = 10'(caps * 37 + 5);
        endcase
        if (paused) begin
          pleft--;
`ifdef GATE_BIST_PAUSE_EN
          pause_a = 1'b1;
`endif
          resp_a = 10'($urandom);
        end else begin
          resp_a  = resp;
          run_sig = misr_step(run_sig, resp);
          caps++;
          if (extra_starts && caps == 2) start_a = 1'b1;
        end
      end
    end
    if (done_edge < 0) begin
      errors++;
      $display("FAIL run_timeout: done not seen within %0d edges, required within 60", edges);
    end
    trail_busy = 0; trail_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      start_a = 1'b0;
      resp_a  = 10'($urandom);
      if (i == 0) pass_after = pass_a;
      trail_busy += int'(busy_a);
      trail_done += int'(done_a);
    end
    trail_pat = pat_a;
    trail_sig = sig_a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b1; start_b = 1'b1; start_c = 1'b1; start_d = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0 || busy_d !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b%b%b%b, required 0000", busy_a, busy_b, busy_c, busy_d); end
    checks++; if (pat_a !== 16'h0 || pat_d !== 16'h0) begin
      errors++; $display("FAIL reset_pat: got %h/%h, required 0000", pat_a, pat_d); end
    checks++; if (sig_a !== 10'h000 || sig_c !== 10'h200) begin
      errors++; $display("FAIL reset_sig: got %h/%h, required 000/200", sig_a, sig_c); end
    checks++; if (done_a !== 1'b0 || pass_a !== 1'b0 || done_d !== 1'b0 || pass_d !== 1'b0) begin
      errors++; $display("FAIL reset_done_pass: got %b%b%b%b, required 0000", done_a, pass_a, done_d, pass_d); end
    checks++; if (st_a !== 2'd0 || st_b !== 2'd0 || st_c !== 2'd0 || st_d !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d, required 0", st_a); end
    rst = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin
      errors++; $display("FAIL reset_beats_start: busy got %b, required 0", busy_a); end
  endtask

  task automatic test_pattern_seq();
    drive_run_a(-1, 0, 0, 1'b0, 1'b1);
    checks++; if (busy_cycles != 4) begin
      errors++; $display("FAIL seq_busy_cycles: got %0d, required 4", busy_cycles); end
    checks++; if (done_edge != 5) begin
      errors++; $display("FAIL seq_done_edge: got %0d, required 5", done_edge); end
    checks++; if (done_pulses + trail_done != 1) begin
      errors++; $display("FAIL seq_done_pulses: got %0d, required 1", done_pulses + trail_done); end
    foreach (obs_pat[i]) begin
      checks++; if (obs_pat[i] !== exp_pat_q[i]) begin
        errors++; $display("FAIL seq_pat[%0d]: got %h, required %h", i, obs_pat[i], exp_pat_q[i]); end
    end
    checks++; if (pass_after !== 1'b1) begin
      errors++; $display("FAIL seq_pass: got %b, required 1", pass_after); end
    checks++; if (trail_pat !== exp_q[3] || trail_sig !== model_sig) begin
      errors++; $display("FAIL seq_idle_hold: got %h/%h, required %h/%h", trail_pat, trail_sig, exp_q[3], model_sig); end
  endtask

  task automatic test_misr_basic();
    logic [9:0] want_sig;
    resp_b = 10'h001;
    for (int r = 0; r < 2; r++) begin
      want_sig = (r == 0) ? 10'h003 : 10'h002;
      @(negedge clk); start_b = 1'b1;
      @(posedge clk); @(negedge clk); start_b = 1'b0;
      checks++; if (busy_b !== 1'b1 || pass_b !== 1'b0 || sig_b !== 10'h000) begin
        errors++; $display("FAIL misr_start[%0d]: busy/pass/sig got %b/%b/%h, required 1/0/000", r, busy_b, pass_b, sig_b); end
      @(posedge clk); @(negedge clk);
      checks++; if (sig_b !== 10'h001) begin
        errors++; $display("FAIL misr_sig1[%0d]: got %h, required 001", r, sig_b); end
      @(posedge clk); @(negedge clk);
      checks++; if (done_b !== 1'b1 || sig_b !== 10'h003) begin
        errors++; $display("FAIL misr_sig2[%0d]: done/sig got %b/%h, required 1/003", r, done_b, sig_b); end
      exp_b = want_sig;
      @(posedge clk); @(negedge clk);
      checks++; if (pass_b !== (r == 0) || done_b !== 1'b0) begin
        errors++; $display("FAIL misr_pass[%0d]: pass/done got %b/%b, required %b/0", r, pass_b, done_b, r == 0); end
    end
  endtask

  task automatic test_misr_wrap();
    resp_c = 10'h000;
    @(negedge clk); start_c = 1'b1;
    @(posedge clk); @(negedge clk); start_c = 1'b0;
    checks++; if (busy_c !== 1'b1 || sig_c !== 10'h200 || pat_c !== 16'hACE1) begin
      errors++; $display("FAIL wrap_load: busy/sig/pat got %b/%h/%h, required 1/200/ace1", busy_c, sig_c, pat_c); end
    @(posedge clk); @(negedge clk);
    checks++; if (done_c !== 1'b1 || sig_c !== 10'h009 || pat_c !== 16'hACE1) begin
      errors++; $display("FAIL wrap_sig: done/sig/pat got %b/%h/%h, required 1/009/ace1", done_c, sig_c, pat_c); end
    exp_c = 10'h009;
    @(posedge clk); @(negedge clk);
    checks++; if (pass_c !== 1'b1) begin
      errors++; $display("FAIL wrap_pass: got %b, required 1", pass_c); end
  endtask

  task automatic test_reset_mid_run();
    int spurious;
    logic [9:0] m;
    m = misr_step(misr_step(10'h000, 10'h3FF), 10'h3FF);
    resp_a = 10'h3FF;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); @(negedge clk); start_a = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    checks++; if (sig_a !== m || busy_a !== 1'b1) begin
      errors++; $display("FAIL midrst_before: sig/busy got %h/%b, required %h/1", sig_a, busy_a, m); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if (busy_a !== 1'b0 || pat_a !== 16'h0 || sig_a !== 10'h000 || done_a !== 1'b0) begin
      errors++; $display("FAIL midrst_after: busy/pat/sig/done got %b/%h/%h/%b, required 0/0000/000/0", busy_a, pat_a, sig_a, done_a); end
    spurious = 0;
    repeat (6) begin @(posedge clk); @(negedge clk); spurious += int'(done_a) + int'(busy_a); end
    checks++; if (spurious != 0) begin
      errors++; $display("FAIL midrst_quiet: got %0d active cycles, required 0", spurious); end
    drive_run_a(-1, 0, 1, 1'b0, 1'b1);
    checks++; if (busy_cycles != 4 || done_edge != 5) begin
      errors++; $display("FAIL midrst_rerun: busy/done_edge got %0d/%0d, required 4/5", busy_cycles, done_edge); end
    checks++; if (sig_at_done !== model_sig || pass_after !== 1'b1) begin
      errors++; $display("FAIL midrst_rerun_sig: got %h/%b, required %h/1", sig_at_done, pass_after, model_sig); end
  endtask

  task automatic test_start_ignored();
    drive_run_a(-1, 0, 1, 1'b1, 1'b1);
    checks++; if (done_pulses + trail_done != 1) begin
      errors++; $display("FAIL ign_done_pulses: got %0d, required 1", done_pulses + trail_done); end
    checks++; if (busy_cycles != 4 || trail_busy != 0) begin
      errors++; $display("FAIL ign_busy: run/trail got %0d/%0d, required 4/0", busy_cycles, trail_busy); end
    foreach (obs_pat[i]) begin
      checks++; if (obs_pat[i] !== exp_pat_q[i]) begin
        errors++; $display("FAIL ign_pat[%0d]: got %h, required %h", i, obs_pat[i], exp_pat_q[i]); end
    end
    checks++; if (sig_at_done !== model_sig) begin
      errors++; $display("FAIL ign_sig: got %h, required %h", sig_at_done, model_sig); end
  endtask

  task automatic test_back_to_back();
    bit want;
    for (int r = 0; r < 4; r++) begin
      want = bit'($urandom_range(0, 1));
      drive_run_a(-1, 0, 1, 1'b0, want);
      foreach (obs_sig[i]) begin
        checks++; if (obs_sig[i] !== exp_sig_q[i]) begin
          errors++; $display("FAIL b2b_sig[%0d][%0d]: got %h, required %h", r, i, obs_sig[i], exp_sig_q[i]); end
      end
      checks++; if (sig_at_done !== model_sig || pass_after !== want) begin
        errors++; $display("FAIL b2b_end[%0d]: sig/pass got %h/%b, required %h/%b", r, sig_at_done, pass_after, model_sig, want); end
      checks++; if (trail_sig !== model_sig || trail_busy != 0) begin
        errors++; $display("FAIL b2b_idle[%0d]: sig/busy got %h/%0d, required %h/0", r, trail_sig, trail_busy, model_sig); end
    end
  endtask

`ifdef GATE_BIST_PAUSE_EN
  task automatic test_pause();
    int         ref_edge;
    logic [9:0] ref_sig;
    drive_run_a(-1, 0, 2, 1'b0, 1'b1);
    ref_edge = done_edge;
    ref_sig  = sig_at_done;
    drive_run_a(1, 3, 2, 1'b0, 1'b1);
    checks++; if (done_edge != ref_edge + 3) begin
      errors++; $display("FAIL pause_done_edge: got %0d, required %0d", done_edge, ref_edge + 3); end
    checks++; if (sig_at_done !== ref_sig || pass_after !== 1'b1) begin
      errors++; $display("FAIL pause_final_sig: got %h/%b, required %h/1", sig_at_done, pass_after, ref_sig); end
    foreach (obs_pat[i]) begin
      checks++; if (obs_pat[i] !== exp_pat_q[i] || obs_sig[i] !== exp_sig_q[i]) begin
        errors++; $display("FAIL pause_cycle[%0d]: pat/sig got %h/%h, required %h/%h", i, obs_pat[i], obs_sig[i], exp_pat_q[i], exp_sig_q[i]); end
      if (obs_paused[i]) begin
        checks++; if (obs_pat[i] !== 16'h0002) begin
          errors++; $display("FAIL pause_hold[%0d]: got %h, required 0002", i, obs_pat[i]); end
      end
    end
  endtask
`endif

  task automatic test_long_random();
    logic [15:0] p;
    logic [9:0]  run_sig;
    logic [9:0]  r;
    int          idx;
    int          edges;
    bit          want;
    bit          seen;
    exp_q.delete();
    p = 16'hACE1;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(p);
      p = lfsr_step(p);
    end
    want = bit'($urandom_range(0, 1));
    run_sig = 10'h000; idx = 0; edges = 0; seen = 1'b0;
    @(negedge clk); start_d = 1'b1;
    while (edges < 300 && !seen) begin
      @(posedge clk); edges++;
      @(negedge clk);
      start_d = 1'b0;
      if (done_d) begin
        seen = 1'b1;
        checks++; if (idx != 256 || sig_d !== run_sig) begin
          errors++; $display("FAIL long_done: patterns/sig got %0d/%h, required 256/%h", idx, sig_d, run_sig); end
        exp_d = want ? run_sig : ~run_sig;
      end else if (busy_d) begin
        checks++; if (idx >= 256 || pat_d !== exp_q[idx]) begin
          errors++; $display("FAIL long_pat[%0d]: got %h, required %h", idx, pat_d, idx < 256 ? exp_q[idx] : 16'hxxxx); end
        r = 10'($urandom);
        resp_d = r;
        run_sig = misr_step(run_sig, r);
        idx++;
      end
    end
    checks++; if (!seen) begin
      errors++; $display("FAIL long_timeout: done not seen within %0d edges, required 257", edges); end
    @(posedge clk); @(negedge clk);
    checks++; if (pass_d !== want || busy_d !== 1'b0) begin
      errors++; $display("FAIL long_pass: pass/busy got %b/%b, required %b/0", pass_d, busy_d, want); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
    resp_a = '0; resp_b = '0; resp_c = '0; resp_d = '0;
`ifdef GATE_BIST_PAUSE_EN
    pause_a = 1'b0;
`endif
    test_reset();
    test_pattern_seq();
    test_misr_basic();
    test_misr_wrap();
    test_reset_mid_run();
    test_start_ignored();
    test_back_to_back();
`ifdef GATE_BIST_PAUSE_EN
    test_pause();
`endif
    test_long_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
